// File: rtl/vsfx_pkg.sv
// Shared definitions for the vector simple-fixed-point (vsfx) unit.
//   LANE_W    : halfword lane width
//   DIV_ITERS : restoring-division iterations (one quotient bit per cycle)
//   state_t   : divider control states
//   HW_MAX/MIN: signed halfword saturation limits
package vsfx_pkg;

    localparam int LANE_W    = 16;
    localparam int DIV_ITERS = 16;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [LANE_W-1:0] HW_MAX = 16'h7FFF;
    localparam logic [LANE_W-1:0] HW_MIN = 16'h8000;

    // Unsigned magnitude of a signed halfword; 0x8000 maps to 0x8000,
    // which is exactly +32768 when read as unsigned.
    function automatic logic [LANE_W-1:0] mag16(input logic [LANE_W-1:0] x);
        return x[LANE_W-1] ? LANE_W'(-x) : x;
    endfunction

endpackage

// File: rtl/vdivsh_lane.sv
// One signed halfword lane of the vdivsh divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture operands a/b (signs, magnitudes, special cases)
//   step       : perform one restoring-division iteration
//   finish     : last iteration; also registers the fixed-up result and flags
//   a, b       : dividend / divisor, two's complement
//   q          : truncated quotient (registered)
//   div0, sat  : divide-by-zero and overflow-saturation flags (registered)
module vdivsh_lane
    import vsfx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              finish,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] q,
    output logic              div0,
    output logic              sat
);

    logic              sa_reg;
    logic              sq_reg;
    logic              zero_reg;
    logic              ovf_reg;
    logic [LANE_W-1:0] mag_b_reg;
    logic [LANE_W:0]   rem_reg;
    // Holds |a| at load; dividend bits shift out of the top while quotient
    // bits shift in at the bottom, so after 16 steps it is the quotient.
    logic [LANE_W-1:0] quo_reg;

    logic [LANE_W:0]   rem_shift;
    logic              fits;
    logic [LANE_W:0]   rem_next;
    logic [LANE_W-1:0] quo_next;
    logic [LANE_W-1:0] result_next;

    always_comb begin
        rem_shift = {rem_reg[LANE_W-1:0], quo_reg[LANE_W-1]};
        fits      = rem_shift >= {1'b0, mag_b_reg};
        rem_next  = fits ? (rem_shift - {1'b0, mag_b_reg}) : rem_shift;
        quo_next  = {quo_reg[LANE_W-2:0], fits};

        // Special cases override the iterated quotient (which is garbage
        // for a zero divisor).
        if (zero_reg)
            result_next = sa_reg ? HW_MIN : HW_MAX;
        else if (ovf_reg)
            result_next = HW_MAX;
        else if (sq_reg)
            result_next = LANE_W'(-quo_next);
        else
            result_next = quo_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_reg    <= 1'b0;
            sq_reg    <= 1'b0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            mag_b_reg <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            q         <= '0;
            div0      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            if (load) begin
                sa_reg    <= a[LANE_W-1];
                sq_reg    <= a[LANE_W-1] ^ b[LANE_W-1];
                zero_reg  <= (b == '0);
                ovf_reg   <= (a == HW_MIN) && (b == '1);
                mag_b_reg <= mag16(b);
                rem_reg   <= '0;
                quo_reg   <= mag16(a);
            end else if (step) begin
                rem_reg <= rem_next;
                quo_reg <= quo_next;
            end
            if (finish) begin
                q    <= result_next;
                div0 <= zero_reg;
                sat  <= ovf_reg;
            end
        end
    end

endmodule

// File: rtl/vdivsh.sv
// Two-lane signed halfword divider with valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   vra, vrb             : packed dividends / divisors, lane1 = [31:16]
//   out_valid / out_ready: result handshake (valid only in DONE)
//   vrt                  : packed truncated quotients
//   div0, sat            : per-lane divide-by-zero / saturation flags
module vdivsh
    import vsfx_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*LANE_W-1:0] vra,
    input  logic [2*LANE_W-1:0] vrb,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*LANE_W-1:0] vrt,
    output logic [1:0]          div0,
    output logic [1:0]          sat
);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic load;
    logic step;
    logic finish;

    always_comb begin
        load   = (state_reg == IDLE) && in_valid && in_ready;
        step   = (state_reg == CALC);
        finish = step && (cnt_reg == CNT_W'(DIV_ITERS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= CALC;
                        cnt_reg   <= '0;
                        in_ready  <= 1'b0;
                    end
                end
                CALC: begin
                    if (cnt_reg == CNT_W'(DIV_ITERS - 1)) begin
                        state_reg <= DONE;
                        cnt_reg   <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE with in_ready set for the next cycle,
                    // so no accept can coincide with this handoff.
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        vdivsh_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load),
            .step   (step),
            .finish (finish),
            .a      (vra[gi*LANE_W +: LANE_W]),
            .b      (vrb[gi*LANE_W +: LANE_W]),
            .q      (vrt[gi*LANE_W +: LANE_W]),
            .div0   (div0[gi]),
            .sat    (sat[gi])
        );
    end

endmodule

// File: tb/tb_vdivsh.sv
// Scoreboard bench for vdivsh: stimulus pushes hand-computed results into a
// queue, a monitor pops and compares on every output handoff.
module tb_vdivsh;

    typedef struct packed {
        logic [31:0] vrt;
        logic [1:0]  div0;
        logic [1:0]  sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] vra = '0;
    logic [31:0] vrb = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] vrt;
    logic [1:0]  div0;
    logic [1:0]  sat;

    int   tests = 0;
    int   fails = 0;
    int   handoffs = 0;
    time  acc_time = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    vdivsh dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vra       (vra),
        .vrb       (vrb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vrt       (vrt),
        .div0      (div0),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid)
                check("latency", 32'($time - acc_time), 32'd165);
            if (out_valid && out_ready) begin
                handoffs++;
                if (sb.size() == 0) begin
                    check("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("vrt", vrt, e.vrt);
                    check("div0", {30'd0, div0}, {30'd0, e.div0});
                    check("sat", {30'd0, sat}, {30'd0, e.sat});
                    $display("[TB] vrt=%08h div0=%b sat=%b (expected %08h %b %b)",
                             vrt, div0, sat, e.vrt, e.div0, e.sat);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check({name, "_timeout"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ev, input logic [1:0] ed, input logic [1:0] es);
        exp_t e;
        wait_ready("issue");
        vra = a;
        vrb = b;
        in_valid = 1'b1;
        @(posedge clk);
        acc_time = $time;
        e.vrt = ev; e.div0 = ed; e.sat = es;
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        int h0;
        logic [31:0] held;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_vrt", vrt, 32'd0);
        check("rst_flags", {28'd0, div0, sat}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-computed quotients.
        issue(32'h0064_0007, 32'h0007_0002, 32'h000E_0003, 2'b00, 2'b00); // 100/7, 7/2
        issue(32'hFF9C_0007, 32'h0007_FF9C, 32'hFFF2_0000, 2'b00, 2'b00); // -100/7, 7/-100
        issue(32'hFFF9_0007, 32'h0002_FFFE, 32'hFFFD_FFFD, 2'b00, 2'b00); // -7/2, 7/-2
        issue(32'h0005_FFFB, 32'h0000_0000, 32'h7FFF_8000, 2'b11, 2'b00); // 5/0, -5/0
        issue(32'h8000_8000, 32'hFFFF_0001, 32'h7FFF_8000, 2'b00, 2'b10); // overflow, -32768/1
        issue(32'h7FFF_0000, 32'h0001_0005, 32'h7FFF_0000, 2'b00, 2'b00); // 32767/1, 0/5
        issue(32'h8000_0009, 32'h8000_FFFD, 32'h0001_FFFD, 2'b00, 2'b00); // -32768/-32768, 9/-3
        issue(32'h0000_0000, 32'h0000_0003, 32'h7FFF_0000, 2'b01 << 1, 2'b00); // 0/0, 0/3
        wait_ready("drain");

        // Backpressure: hold the result, try a second issue while busy.
        out_ready = 1'b0;
        issue(32'h03E8_FC18, 32'h000A_0021, 32'h0064_FFE2, 2'b00, 2'b00); // 1000/10, -1000/33
        begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) check("bp_timeout", {31'd0, out_valid}, 32'd1);
        end
        held = vrt;
        h0 = handoffs;
        vra = 32'h1111_2222;
        vrb = 32'h0003_0004;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_vrt_stable", vrt, held);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("bp_one_handoff", 32'(handoffs - h0), 32'd1);
        check("bp_idle", {31'd0, in_ready}, 32'd1);
        check("bp_queue_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of CALC.
        issue(32'h0064_0064, 32'h0005_0005, 32'h0014_0014, 2'b00, 2'b00);
        repeat (8) @(posedge clk);
        #1;
        h0 = handoffs;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_vrt", vrt, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h0064_0007, 32'h0003_0002, 32'h0021_0003, 2'b00, 2'b00); // 100/3, 7/2
        wait_ready("post_reset");
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_handoffs", 32'(handoffs - h0), 32'd1);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vdivsh.md
# vdivsh

Two-lane signed halfword divider for the vector simple-fixed-point (vsfx) unit. It divides each signed 16-bit lane of `vra` by the matching lane of `vrb` and returns the truncated quotient in `vrt`. It is the multi-cycle counterpart to the single-cycle halving/averaging ops: the combinational ops only divide by 2, and this block handles arbitrary divisors. It sits behind a valid/ready handshake so the issue logic can stall on it.

## Interface
- `LANE_W`, 16, lane width in bits; fixed at 16, carried as a parameter for the package constants only.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `vra`  in  32  dividends: lane1 = `[31:16]`, lane0 = `[15:0]`, two's complement.
- `vrb`  in  32  divisors, same lane layout.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `vrt`  out  32  quotients, same lane layout.
- `div0`  out  2  per-lane divide-by-zero flag (bit1 = lane1).
- `sat`  out  2  per-lane overflow saturation flag.

## Operation
- States:
  - IDLE: `in_ready` = 1.
  - CALC: 16 iterations.
  - DONE: `out_valid` = 1.
- Transitions:
  - IDLE→CALC when `in_valid & in_ready`. Operands are captured on that edge.
  - CALC→DONE when the iteration counter reaches 15.
  - DONE→IDLE when `out_ready` is high.
- Per lane at capture:
  - Record the signs: `sa` = a[15], `sb` = b[15], quotient sign `sq` = `sa ^ sb`.
  - Store magnitudes as 16-bit unsigned values; |−32768| = 0x8000 is valid.
- CALC uses restoring division, one quotient bit per cycle, MSB first:
  - 17-bit partial remainder `r = {r[15:0], dividend_bit}`.
  - If `r >= |b|`, then `r -= |b|` and the quotient bit is 1.
- Result fix-up, applied on entry to DONE:
  - If `sq` = 1, negate the magnitude quotient; truncation is toward zero.
  - The remainder is discarded.
- Divide by zero (b = 0):
  - The lane result is 0x7FFF if a ≥ 0, else 0x8000.
  - `div0` for that lane = 1.
  - The iteration still runs its full 16 cycles and its output is ignored.
- Overflow (a = 0x8000, b = 0xFFFF): the lane result is 0x7FFF and `sat` for that lane = 1.
- The two lanes are independent and always complete together.
- `vrt`, `div0` and `sat` are registered. They change only on entry to DONE and are held stable while `out_valid` = 1.

## Timing
- Reset values:
  - State = IDLE, `in_ready` = 1, `out_valid` = 0.
  - `vrt` = 0, `div0` = 0, `sat` = 0, counter = 0.
- Latency: if operands are accepted at edge N, `out_valid` rises after edge N+16, i.e. 16 cycles in CALC.
- Minimum initiation interval: 18 cycles (accept, 16 × CALC, DONE with `out_ready` = 1).
- `in_ready` is low in CALC and DONE. A new accept is not allowed in the same cycle as a DONE handoff.
- Backpressure: DONE holds indefinitely while `out_ready` = 0; the outputs do not change.
- `in_valid` while busy is ignored; no operand capture takes place.
- `rst_n` low mid-CALC or mid-DONE:
  - Returns to IDLE immediately and asynchronously, with all outputs at their reset values.
  - The in-flight result is lost and no `out_valid` pulse appears.

## Structure
- Package `vsfx_pkg` holds:
  - `LANE_W` = 16 and `DIV_ITERS` = 16.
  - The state enum {IDLE, CALC, DONE}.
  - Constants `HW_MAX` = 16'h7FFF and `HW_MIN` = 16'h8000.
- Sub-module `vdivsh_lane`:
  - Does per-lane sign capture, the magnitude remainder/quotient registers, the step logic, and the fix-up and flag logic.
  - Instantiated twice.
- The top level holds the FSM, the shared iteration counter and the handshake.

## Test plan
- Simple positive divide: `vra` = {100, 7}, `vrb` = {7, 2} → `vrt` = {0x000E, 0x0003}. `out_valid` rises exactly 16 cycles after accept; `div0` = `sat` = 0.
- Mixed signs: `vra` = {−100, 7}, `vrb` = {7, −100} → `vrt` = {0xFFF2, 0x0000}. The −7/2 lane case gives 0xFFFD (truncation toward zero).
- Divide by zero: `vra` = {5, −5}, `vrb` = {0, 0} → `vrt` = {0x7FFF, 0x8000}, `div0` = 2'b11.
- Extremes: `vra` = {0x8000, 0x8000}, `vrb` = {0xFFFF, 0x0001} → `vrt` = {0x7FFF, 0x8000}, `sat` = 2'b10.
- Backpressure: hold `out_ready` = 0 for 10 cycles in DONE → `vrt` is stable, `in_ready` = 0, and a second `in_valid` is ignored. Release gives one handoff and returns to IDLE.
- Reset mid-op: drop `rst_n` at CALC iteration 8 → `out_valid` = 0 and `vrt` = 0 immediately. After release, a new operation completes correctly.
